rfg_byte_protocol_decoder: RTL and testbench
============================================

Name: rfg_byte_protocol_decoder

Overview:
- Upstream command stage of the register file: consumes the host byte stream arriving from the FTDI synchronous FIFO (AXIS slave) and decodes framed read/write commands.
- Drives the register-file R/W bus (rfg_address, rfg_write_value, rfg_write, rfg_write_last, rfg_read).
- Returns read data to the host TX FIFO over an AXIS master.
- Handles burst transfers, with optional address auto-increment.

Parameters:
- READ_TIMEOUT, 4, cycles to wait for rfg_read_valid after rfg_read before substituting 8'h00 (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_s_axis_tdata  in  8  host byte
- rx_s_axis_tvalid  in  1  host byte valid
- rx_s_axis_tready  out  1  byte accepted when tvalid&&tready
- tx_m_axis_tdata  out  8  read response byte
- tx_m_axis_tvalid  out  1  response valid
- tx_m_axis_tready  in  1  TX FIFO ready
- rfg_address  out  8  register address
- rfg_write_value  out  8  write data
- rfg_write  out  1  one-cycle write strobe
- rfg_write_last  out  1  with rfg_write on final byte of burst
- rfg_read  out  1  one-cycle read strobe
- rfg_read_valid  in  1  read data valid
- rfg_read_value  in  8  read data
- busy  out  1  frame in progress (state != IDLE)
- read_timeout_err  out  1  sticky; set on any read timeout

Behaviour:
- Frame format: CMD, ADDR, LEN, then LEN+1 data bytes (write frames only).
  - CMD[7]: 1=write, 0=read.
  - CMD[6]: 1=auto-increment address. CMD[5:0] ignored.
  - Burst length = LEN+1, i.e. 1..256 bytes.
- Reset (async assert): state IDLE; every output and internal register = 0, including rx_s_axis_tready, tx_m_axis_tvalid, the strobes, rfg_address and read_timeout_err. A partially received frame is discarded. Release is synchronous to clk.
- States: IDLE, ADDR, LEN, WDATA, RREQ, RWAIT, RSEND.
- IDLE / ADDR / LEN:
  - rx_s_axis_tready=1.
  - Each accepted byte is latched and advances IDLE->ADDR->LEN.
  - From LEN, go to WDATA if write, else RREQ.
  - The remaining-count register is loaded with LEN.
- WDATA:
  - rx_s_axis_tready=1.
  - Accepted byte at edge t: at t+1, rfg_write=1 and rfg_write_value=byte for exactly one cycle, with rfg_address = current address.
  - rfg_write_last=1 on the byte where remaining==0, then go to IDLE.
  - Otherwise decrement remaining. If auto-inc, address+1 takes effect from the next write.
  - Back-to-back accepted bytes give back-to-back strobes with no bubbles.
- RREQ:
  - rx_s_axis_tready=0; the RX stream stalls for the whole read burst.
  - Assert rfg_read for one cycle, then go to RWAIT and clear the timeout counter.
- RWAIT:
  - rfg_read_valid=1: capture rfg_read_value into the holding register and go to RSEND.
  - Timeout counter reaches READ_TIMEOUT first: hold 8'h00, set read_timeout_err, go to RSEND.
  - rfg_read_valid arriving later is ignored.
- RSEND:
  - tx_m_axis_tvalid=1 with the held byte. tdata/tvalid stay stable until tready.
  - On handshake: if remaining==0, go to IDLE; else decrement remaining, apply address+1 if auto-inc, and go to RREQ.
  - At most one outstanding read; per-byte read cost is at least 3 cycles.
- Address arithmetic: 8-bit; 8'hFF+1 wraps to 8'h00, with no error. Without auto-inc, all accesses use ADDR, which allows FIFO-port bursts (for example a loopback drain).
- rfg_address is held between accesses; it changes only when ADDR is latched or when it increments.
- rfg_write and rfg_read are never asserted together.
- read_timeout_err clears only on rst.
- busy=1 from the cycle after CMD is accepted until the cycle after the return to IDLE.

Test Plan:
- Single write: bytes 0x80,0x00,0x00,0x5A -> exactly one rfg_write pulse with address 0x00, value 0x5A and rfg_write_last=1; busy falls afterwards.
- Auto-inc write burst: 0xC0,0x07,0x03,0x11,0x22,0x33,0x44 -> four consecutive strobes at addresses 0x07..0x0A with those values; rfg_write_last only on 0x44.
- Read burst with TX backpressure:
  - Stimulus: 0x40,0x01,0x01. Responder returns valid one cycle after rfg_read with values 0xAB, 0xCD. tx_m_axis_tready is held low for 5 cycles.
  - Required: TX emits 0xAB then 0xCD; data stays stable while stalled; second rfg_read only after the first handshake; rx_s_axis_tready=0 throughout.
- Timeout: read of address 0x20 (0x00,0x20,0x00) with rfg_read_valid never asserted -> after READ_TIMEOUT=4 cycles, TX byte 0x00 and read_timeout_err=1 (sticky).
- Wrap and no-inc: 0xC0,0xFF,0x01,0x01,0x02 -> writes to 0xFF then 0x00. 0x80,0x05,0x02,0xA,0xB,0xC -> three writes, all to 0x05.
- Reset mid-frame: assert rst after CMD and ADDR of a write frame -> all outputs 0 immediately. After release, a fresh 4-byte write frame decodes correctly; the stale bytes have no effect.

Source files
------------

// File: rtl/rfg_byte_protocol_decoder.sv
// Host byte-stream command decoder for the register file: parses CMD/ADDR/LEN frames,
// drives the register R/W bus and streams read data back to the host TX FIFO.
module rfg_byte_protocol_decoder #(
  parameter int unsigned READ_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_s_axis_tdata,
  input  logic       rx_s_axis_tvalid,
  output logic       rx_s_axis_tready,
  output logic [7:0] tx_m_axis_tdata,
  output logic       tx_m_axis_tvalid,
  input  logic       tx_m_axis_tready,
  output logic [7:0] rfg_address,
  output logic [7:0] rfg_write_value,
  output logic       rfg_write,
  output logic       rfg_write_last,
  output logic       rfg_read,
  input  logic       rfg_read_valid,
  input  logic [7:0] rfg_read_value,
  output logic       busy,
  output logic       read_timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StWdata,
    StRreq,
    StRwait,
    StRsend
  } state_e;

  localparam logic [3:0] TimeoutLast = 4'(READ_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       cmd_wr_q, cmd_wr_d;
  logic       cmd_inc_q, cmd_inc_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] wr_value_q, wr_value_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       wr_last_q, wr_last_d;
  logic       tready_q, tready_d;
  logic       timeout_err_q, timeout_err_d;
  logic [3:0] timer_q, timer_d;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = rx_s_axis_tvalid && tready_q;
  assign tx_fire = (state_q == StRsend) && tx_m_axis_tready;

  always_comb begin
    state_d       = state_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_inc_d     = cmd_inc_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    hold_d        = hold_q;
    wr_value_d    = wr_value_q;
    wr_strobe_d   = 1'b0;
    wr_last_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;

    // The address seen by a write strobe is the current one; bump it right after.
    if (wr_strobe_q && !wr_last_q && cmd_inc_q) begin
      addr_d = addr_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          cmd_wr_d  = rx_s_axis_tdata[7];
          cmd_inc_d = rx_s_axis_tdata[6];
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (rx_fire) begin
          addr_d  = rx_s_axis_tdata;
          state_d = StLen;
        end
      end
      StLen: begin
        if (rx_fire) begin
          remaining_d = rx_s_axis_tdata;
          state_d     = cmd_wr_q ? StWdata : StRreq;
        end
      end
      StWdata: begin
        if (rx_fire) begin
          wr_strobe_d = 1'b1;
          wr_value_d  = rx_s_axis_tdata;
          if (remaining_q == 8'd0) begin
            wr_last_d = 1'b1;
            state_d   = StIdle;
          end else begin
            remaining_d = remaining_q - 8'd1;
          end
        end
      end
      StRreq: begin
        timer_d = 4'd0;
        state_d = StRwait;
      end
      StRwait: begin
        if (rfg_read_valid) begin
          hold_d  = rfg_read_value;
          state_d = StRsend;
        end else if (timer_q == TimeoutLast) begin
          hold_d        = 8'h00;
          timeout_err_d = 1'b1;
          state_d       = StRsend;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      StRsend: begin
        if (tx_fire) begin
          if (remaining_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            remaining_d = remaining_q - 8'd1;
            if (cmd_inc_q) begin
              addr_d = addr_q + 8'd1;
            end
            state_d = StRreq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    tready_d = (state_d == StIdle) || (state_d == StAddr) ||
               (state_d == StLen) || (state_d == StWdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cmd_wr_q      <= 1'b0;
      cmd_inc_q     <= 1'b0;
      addr_q        <= 8'h00;
      remaining_q   <= 8'h00;
      hold_q        <= 8'h00;
      wr_value_q    <= 8'h00;
      wr_strobe_q   <= 1'b0;
      wr_last_q     <= 1'b0;
      tready_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_inc_q     <= cmd_inc_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      hold_q        <= hold_d;
      wr_value_q    <= wr_value_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_last_q     <= wr_last_d;
      tready_q      <= tready_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
    end
  end

  assign rx_s_axis_tready = tready_q;
  assign tx_m_axis_tdata  = hold_q;
  assign tx_m_axis_tvalid = (state_q == StRsend);
  assign rfg_address      = addr_q;
  assign rfg_write_value  = wr_value_q;
  assign rfg_write        = wr_strobe_q;
  assign rfg_write_last   = wr_last_q;
  assign rfg_read         = (state_q == StRreq);
  assign busy             = (state_q != StIdle);
  assign read_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rfg_byte_protocol_decoder.sv
// Directed bench for rfg_byte_protocol_decoder: drives host frames, logs bus/TX activity
// on the falling edge and compares against hand-computed expectations.
module tb_rfg_byte_protocol_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_tdata = 8'h00;
  logic       rx_tvalid = 1'b0;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready = 1'b0;
  logic [7:0] rfg_address;
  logic [7:0] rfg_write_value;
  logic       rfg_write;
  logic       rfg_write_last;
  logic       rfg_read;
  logic       rfg_read_valid = 1'b0;
  logic [7:0] rfg_read_value = 8'h00;
  logic       busy;
  logic       read_timeout_err;

  rfg_byte_protocol_decoder #(
    .READ_TIMEOUT(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_s_axis_tdata  (rx_tdata),
    .rx_s_axis_tvalid (rx_tvalid),
    .rx_s_axis_tready (rx_tready),
    .tx_m_axis_tdata  (tx_tdata),
    .tx_m_axis_tvalid (tx_tvalid),
    .tx_m_axis_tready (tx_tready),
    .rfg_address      (rfg_address),
    .rfg_write_value  (rfg_write_value),
    .rfg_write        (rfg_write),
    .rfg_write_last   (rfg_write_last),
    .rfg_read         (rfg_read),
    .rfg_read_valid   (rfg_read_valid),
    .rfg_read_value   (rfg_read_value),
    .busy             (busy),
    .read_timeout_err (read_timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event logs filled by the monitor.
  logic [7:0] wr_a [64];
  logic [7:0] wr_v [64];
  logic       wr_l [64];
  int         wr_c [64];
  int         wn = 0;
  logic [7:0] tx_d [64];
  int         tn = 0;
  logic [7:0] rd_a [64];
  int         rd_tx [64];
  int         rd_c [64];
  int         rn = 0;
  int         both_err = 0;
  int         stab_err = 0;
  int         rdy_err = 0;
  int         tv_cyc = 0;
  logic       rd_chk = 1'b0;
  logic       prev_tv = 1'b0;
  logic       prev_tr = 1'b0;
  logic [7:0] prev_td = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (rfg_write) begin
        wr_a[wn] = rfg_address;
        wr_v[wn] = rfg_write_value;
        wr_l[wn] = rfg_write_last;
        wr_c[wn] = cyc;
        wn++;
      end
      if (rfg_read) begin
        rd_a[rn]  = rfg_address;
        rd_tx[rn] = tn;
        rd_c[rn]  = cyc;
        rn++;
      end
      if (rfg_write && rfg_read) both_err++;
      if (rd_chk && rx_tready) rdy_err++;
      if (prev_tv && !prev_tr && (!tx_tvalid || tx_tdata != prev_td)) stab_err++;
      if (tx_tvalid && !prev_tv) tv_cyc = cyc;
      if (tx_tvalid && tx_tready) begin
        tx_d[tn] = tx_tdata;
        tn++;
      end
    end
    prev_tv = tx_tvalid;
    prev_tr = tx_tready;
    prev_td = tx_tdata;
  end

  // Read responder: answers one cycle after rfg_read when enabled.
  logic       resp_en = 1'b0;
  logic [7:0] resp_vals [4];
  initial begin
    int  idx;
    logic pend;
    idx = 0;
    forever begin
      @(negedge clk);
      pend = rfg_read && resp_en;
      @(posedge clk);
      #1;
      rfg_read_valid = pend;
      if (pend) begin
        rfg_read_value = resp_vals[idx];
        idx++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    @(negedge clk);
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    while (!rx_tready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("rx_accept", 32'(k < 50), 1);
    @(posedge clk);
    #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_tx(input int target);
    int k;
    k = 0;
    while (tn < target && k < 100) begin
      @(posedge clk);
      k++;
    end
    check_eq("tx_wait", 32'(tn >= target), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_rx_tready"}, 32'(rx_tready), 0);
    check_eq({tag, "_tx_tvalid"}, 32'(tx_tvalid), 0);
    check_eq({tag, "_write"}, 32'(rfg_write), 0);
    check_eq({tag, "_read"}, 32'(rfg_read), 0);
    check_eq({tag, "_addr"}, 32'(rfg_address), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_err"}, 32'(read_timeout_err), 0);
  endtask

  initial begin
    int wb, tb, rb;
    logic [7:0] exp_a [4];
    logic [7:0] exp_v [4];

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write.
    wb = wn;
    send_seq('{8'h80, 8'h00, 8'h00, 8'h5A});
    repeat (3) @(negedge clk);
    check_eq("w1_count", 32'(wn - wb), 1);
    check_eq("w1_addr", 32'(wr_a[wb]), 32'h00);
    check_eq("w1_val", 32'(wr_v[wb]), 32'h5A);
    check_eq("w1_last", 32'(wr_l[wb]), 1);
    check_eq("w1_busy", 32'(busy), 0);

    // Auto-increment burst of four.
    wb = wn;
    exp_a = '{8'h07, 8'h08, 8'h09, 8'h0A};
    exp_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_seq('{8'hC0, 8'h07, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44});
    repeat (3) @(negedge clk);
    check_eq("w4_count", 32'(wn - wb), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("w4_addr%0d", i), 32'(wr_a[wb+i]), 32'(exp_a[i]));
      check_eq($sformatf("w4_val%0d", i), 32'(wr_v[wb+i]), 32'(exp_v[i]));
      check_eq($sformatf("w4_last%0d", i), 32'(wr_l[wb+i]), 32'(i == 3));
    end
    check_eq("w4_no_bubbles", 32'(wr_c[wb+3] - wr_c[wb]), 3);

    // Read burst under TX backpressure.
    tb = tn;
    rb = rn;
    resp_vals[0] = 8'hAB;
    resp_vals[1] = 8'hCD;
    resp_en = 1'b1;
    tx_tready = 1'b0;
    send_seq('{8'h40, 8'h01, 8'h01});
    rd_chk = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("r_stall_valid", 32'(tx_tvalid), 1);
    check_eq("r_stall_data", 32'(tx_tdata), 32'hAB);
    check_eq("r_stall_one_read", 32'(rn - rb), 1);
    @(posedge clk);
    #1;
    tx_tready = 1'b1;
    wait_tx(tb + 2);
    rd_chk = 1'b0;
    #1;
    tx_tready = 1'b0;
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("r_byte0", 32'(tx_d[tb]), 32'hAB);
    check_eq("r_byte1", 32'(tx_d[tb+1]), 32'hCD);
    check_eq("r_reads", 32'(rn - rb), 2);
    check_eq("r_addr0", 32'(rd_a[rb]), 32'h01);
    check_eq("r_addr1", 32'(rd_a[rb+1]), 32'h02);
    check_eq("r_second_after_hs", 32'(rd_tx[rb+1]), 32'(tb + 1));
    check_eq("r_stable", 32'(stab_err), 0);
    check_eq("r_rx_stalled", 32'(rdy_err), 0);
    check_eq("r_busy", 32'(busy), 0);
    check_eq("r_no_err", 32'(read_timeout_err), 0);

    // Read timeout.
    tb = tn;
    rb = rn;
    tx_tready = 1'b1;
    send_seq('{8'h00, 8'h20, 8'h00});
    wait_tx(tb + 1);
    repeat (2) @(negedge clk);
    check_eq("to_byte", 32'(tx_d[tb]), 32'h00);
    check_eq("to_addr", 32'(rd_a[rb]), 32'h20);
    check_eq("to_latency", 32'(tv_cyc - rd_c[rb]), 5);
    check_eq("to_err", 32'(read_timeout_err), 1);

    // Address wrap with auto-increment, then fixed-address burst.
    wb = wn;
    send_seq('{8'hC0, 8'hFF, 8'h01, 8'h01, 8'h02});
    send_seq('{8'h80, 8'h05, 8'h02, 8'h0A, 8'h0B, 8'h0C});
    repeat (3) @(negedge clk);
    check_eq("wrap_count", 32'(wn - wb), 5);
    check_eq("wrap_addr0", 32'(wr_a[wb]), 32'hFF);
    check_eq("wrap_addr1", 32'(wr_a[wb+1]), 32'h00);
    check_eq("wrap_val1", 32'(wr_v[wb+1]), 32'h02);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("noinc_addr%0d", i), 32'(wr_a[wb+2+i]), 32'h05);
      check_eq($sformatf("noinc_val%0d", i), 32'(wr_v[wb+2+i]), 32'(8'h0A + 8'(i)));
    end
    check_eq("err_sticky", 32'(read_timeout_err), 1);

    // Reset in the middle of a write frame.
    send_seq('{8'h80, 8'h33});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    wb = wn;
    send_seq('{8'h80, 8'h44, 8'h00, 8'h99});
    repeat (3) @(negedge clk);
    check_eq("post_rst_count", 32'(wn - wb), 1);
    check_eq("post_rst_addr", 32'(wr_a[wb]), 32'h44);
    check_eq("post_rst_val", 32'(wr_v[wb]), 32'h99);
    check_eq("post_rst_last", 32'(wr_l[wb]), 1);
    check_eq("never_rw_together", 32'(both_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
